// File: rtl/bit_reverse_stream_buffer.sv
// bit_reverse_stream_buffer
//   Streaming ping-pong reorder buffer. Samples arrive one per cycle in
//   natural order over a valid/ready handshake and each N-sample frame is
//   emitted in bit-reversed order (or natural order when mode_natural was
//   set with the frame's first sample). One bank is written while the other
//   is read, so one sample per cycle is sustained in both directions.
//
// Ports
//   clk          clock, all logic on the rising edge
//   rst          synchronous reset, active-high
//   in_data      input sample, natural order
//   in_valid     in_data valid
//   in_ready     buffer can accept in_data this cycle
//   mode_natural 1 = emit this frame in natural order (sampled on first sample)
//   out_data     output sample
//   out_valid    out_data valid
//   out_ready    downstream accepts out_data
//   out_index    natural (write) index of the sample on out_data
//   out_last     out_data is the final sample of its frame
module bit_reverse_stream_buffer #(
    parameter int unsigned N    = 8,
    parameter int unsigned SIZE = 32,
    parameter int unsigned LOGN = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            mode_natural,
    output logic [SIZE-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LOGN-1:0] out_index,
    output logic            out_last
);

    logic [SIZE-1:0] mem [2][N];

    logic [1:0]      bank_full;
    logic [1:0]      bank_mode;
    logic            wr_bank;
    logic            rd_bank;
    logic [LOGN-1:0] wr_cnt;
    logic [LOGN-1:0] rd_cnt;
    logic [LOGN-1:0] rd_addr;
    logic            wr_fire;
    logic            rd_fire;
    logic            wr_wrap;
    logic            rd_wrap;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LOGN; i++) begin
            r[LOGN-1-i] = v[i];
        end
        return r;
    endfunction

    always_comb begin
        in_ready  = !rst && !bank_full[wr_bank];
        out_valid = !rst && bank_full[rd_bank];
        rd_addr   = bank_mode[rd_bank] ? rd_cnt : bitrev(rd_cnt);
        wr_fire   = in_valid && in_ready;
        rd_fire   = out_valid && out_ready;
        wr_wrap   = (wr_cnt == LOGN'(N - 1));
        rd_wrap   = (rd_cnt == LOGN'(N - 1));
        out_data  = out_valid ? mem[rd_bank][rd_addr] : '0;
        out_index = out_valid ? rd_addr : '0;
        out_last  = out_valid && rd_wrap;
    end

    // Sample storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_bank][wr_cnt] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full <= '0;
            bank_mode <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
        end else begin
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_cnt == '0) begin
                    bank_mode[wr_bank] <= mode_natural;
                end
                if (wr_wrap) begin
                    wr_bank <= !wr_bank;
                end
            end
            if (rd_fire) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_wrap) begin
                    rd_bank <= !rd_bank;
                end
            end
            // A write can only fill a non-full bank and a read can only
            // release a full one, so the two never target the same bank.
            for (int unsigned b = 0; b < 2; b++) begin
                if (wr_fire && wr_wrap && (wr_bank == 1'(b))) begin
                    bank_full[b] <= 1'b1;
                end else if (rd_fire && rd_wrap && (rd_bank == 1'(b))) begin
                    bank_full[b] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_reverse_stream_buffer.sv
// tb_bit_reverse_stream_buffer
//   Self-checking bench for bit_reverse_stream_buffer. A frame-level
//   reference model (queues of completed frames plus a partial frame)
//   predicts every output each cycle; a constant vector table and directed
//   sequences cover single frames, back-to-back streaming, back-pressure,
//   per-frame mode, reset mid-stream and an N=16 instance.
module tb_bit_reverse_stream_buffer;

    localparam int unsigned N   = 8;
    localparam int unsigned W   = 32;
    localparam int unsigned LN  = 3;
    localparam int unsigned N2  = 16;
    localparam int unsigned W2  = 16;
    localparam int unsigned LN2 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance, N=8 SIZE=32
    logic          rst = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mode_natural = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [LN-1:0] out_index;
    logic          out_last;

    // second instance, N=16 SIZE=16
    logic           rst2 = 1'b1;
    logic [W2-1:0]  in_data2 = '0;
    logic           in_valid2 = 1'b0;
    logic           in_ready2;
    logic           mode2 = 1'b0;
    logic [W2-1:0]  out_data2;
    logic           out_valid2;
    logic           out_ready2 = 1'b1;
    logic [LN2-1:0] out_index2;
    logic           out_last2;

    bit_reverse_stream_buffer #(.N(N), .SIZE(W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode_natural(mode_natural), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .out_last(out_last)
    );

    bit_reverse_stream_buffer #(.N(N2), .SIZE(W2)) dut16 (
        .clk(clk), .rst(rst2), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .mode_natural(mode2), .out_data(out_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_index(out_index2),
        .out_last(out_last2)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    int unsigned brs[8]    = '{0, 4, 2, 6, 1, 5, 3, 7};
    int unsigned exp16[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    // ---------------- reference model ----------------
    logic [W-1:0] cq[$];     // completed frames, N samples each, oldest first
    bit           cmode[$];  // natural-order flag per completed frame
    logic [W-1:0] pq[$];     // frame being received
    bit           pmode;
    int unsigned  pos = 0;   // samples already sent from the oldest frame
    bit           m_acc = 1'b0;

    function automatic int unsigned rev(input int unsigned x, input int unsigned bits);
        int unsigned r = 0;
        int unsigned v = x;
        repeat (bits) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
        return r;
    endfunction

    task automatic predict(output bit er, output bit ev, output logic [W-1:0] ed,
                           output int unsigned ei, output bit el);
        int unsigned nfull = cq.size() / N;
        er = !rst && (nfull < 2);
        ev = !rst && (nfull > 0);
        ed = '0;
        ei = 0;
        el = 1'b0;
        if (ev) begin
            ei = cmode[0] ? pos : rev(pos, LN);
            ed = cq[ei];
            el = (pos == N - 1);
        end
    endtask

    task automatic check_model();
        bit er, ev, el;
        logic [W-1:0] ed;
        int unsigned ei;
        predict(er, ev, ed, ei, el);
        n_vec++;
        if (in_ready !== er || out_valid !== ev || out_data !== ed ||
            out_index !== LN'(ei) || out_last !== el) begin
            n_err++;
            $display("FAIL model t=%0t: got rdy=%b vld=%b data=%0h idx=%0d last=%b, required rdy=%b vld=%b data=%0h idx=%0d last=%b",
                     $time, in_ready, out_valid, out_data, out_index, out_last,
                     er, ev, ed, ei, el);
        end
    endtask

    task automatic update_model();
        bit er, ev, el;
        logic [W-1:0] ed;
        int unsigned ei;
        if (rst) begin
            cq.delete();
            cmode.delete();
            pq.delete();
            pos   = 0;
            m_acc = 1'b0;
        end else begin
            predict(er, ev, ed, ei, el);
            if (ev && out_ready) begin
                pos++;
                if (pos == N) begin
                    repeat (N) void'(cq.pop_front());
                    void'(cmode.pop_front());
                    pos = 0;
                end
            end
            m_acc = in_valid && er;
            if (m_acc) begin
                if (pq.size() == 0) pmode = mode_natural;
                pq.push_back(in_data);
                if (pq.size() == N) begin
                    foreach (pq[i]) cq.push_back(pq[i]);
                    cmode.push_back(pmode);
                    pq.delete();
                end
            end
        end
    endtask

    // ---------------- cycle helpers ----------------
    task automatic half();
        @(negedge clk);
        check_model();
    endtask

    task automatic adv();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic cyc();
        half();
        adv();
    endtask

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic stream(input int unsigned nsamp, input logic [W-1:0] base, input bit rdy,
                          input bit m_first, input bit m_rest);
        int unsigned sent = 0;
        int unsigned guard = 0;
        while (sent < nsamp && guard < 400) begin
            in_valid     = 1'b1;
            in_data      = base + sent;
            mode_natural = (sent == 0) ? m_first : m_rest;
            out_ready    = rdy;
            cyc();
            if (m_acc) sent++;
            guard++;
        end
        in_valid = 1'b0;
        if (sent < nsamp) begin
            n_vec++;
            n_err++;
            $display("FAIL stream_timeout: got %0d accepted, required %0d", sent, nsamp);
        end
    endtask

    task automatic drain(input int unsigned maxcyc);
        int unsigned guard = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (cq.size() > 0 && guard < maxcyc) begin
            cyc();
            guard++;
        end
        if (cq.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d samples left, required 0", cq.size());
        end
    endtask

    task automatic expect_frame(input string name, input logic [W-1:0] base, input bit natural);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int unsigned k = 0; k < N; k++) begin
            half();
            check({name, "_valid"}, W'(out_valid), W'(1));
            check({name, "_data"}, out_data, base + (natural ? k : brs[k]));
            check({name, "_last"}, W'(out_last), W'(k == N - 1));
            adv();
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit           rst;
        bit           vld;
        logic [W-1:0] din;
        bit           mode;
        bit           ordy;
        bit           e_rdy;
        bit           e_vld;
        logic [W-1:0] e_data;
        bit           e_last;
    } vec_t;

    vec_t tbl[18];

    initial begin
        tbl[0] = '{1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0};
        for (int unsigned k = 0; k < 8; k++)
            tbl[1 + k] = '{1'b0, 1'b1, W'(k), 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0};
        for (int unsigned k = 0; k < 8; k++)
            tbl[9 + k] = '{1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1, W'(brs[k]), (k == 7)};
        tbl[17] = '{1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0};

        // one frame, bit-reversed, table driven
        foreach (tbl[i]) begin
            rst          = tbl[i].rst;
            in_valid     = tbl[i].vld;
            in_data      = tbl[i].din;
            mode_natural = tbl[i].mode;
            out_ready    = tbl[i].ordy;
            half();
            n_vec++;
            if (in_ready !== tbl[i].e_rdy || out_valid !== tbl[i].e_vld ||
                out_data !== tbl[i].e_data || out_last !== tbl[i].e_last ||
                out_index !== tbl[i].e_data[LN-1:0]) begin
                n_err++;
                $display("FAIL table[%0d]: got rdy=%b vld=%b data=%0h idx=%0d last=%b, required rdy=%b vld=%b data=%0h idx=%0d last=%b",
                         i, in_ready, out_valid, out_data, out_index, out_last,
                         tbl[i].e_rdy, tbl[i].e_vld, tbl[i].e_data,
                         tbl[i].e_data[LN-1:0], tbl[i].e_last);
            end
            adv();
        end

        // three frames back to back, no bubbles
        stream(24, 0, 1'b1, 1'b0, 1'b0);
        drain(40);

        // back-pressure: two frames fill both banks, 17th sample held
        stream(16, 0, 1'b0, 1'b0, 1'b0);
        in_valid  = 1'b1;
        in_data   = 16;
        out_ready = 1'b0;
        repeat (3) cyc();
        half();
        check("full_in_ready", W'(in_ready), W'(0));
        check("full_out_valid", W'(out_valid), W'(1));
        check("full_first_out", out_data, 0);
        adv();
        stream(8, 16, 1'b1, 1'b0, 1'b0);
        drain(60);

        // per-frame mode: natural, then bit-reversed
        stream(8, 40, 1'b1, 1'b1, 1'b0);
        expect_frame("mode_nat", 40, 1'b1);
        stream(8, 50, 1'b1, 1'b0, 1'b1);
        expect_frame("mode_rev", 50, 1'b0);

        // reset mid-frame
        stream(5, 200, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        half();
        check("rst_in_ready", W'(in_ready), W'(0));
        adv();
        rst = 1'b0;
        half();
        check("post_rst_valid", W'(out_valid), W'(0));
        adv();
        // reset with a full frame buffered
        stream(8, 300, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        half();
        check("buffered_valid", W'(out_valid), W'(1));
        adv();
        rst = 1'b1;
        half();
        check("rst2_in_ready", W'(in_ready), W'(0));
        check("rst2_out_valid", W'(out_valid), W'(0));
        adv();
        rst = 1'b0;
        half();
        check("post_rst2_valid", W'(out_valid), W'(0));
        check("post_rst2_data", out_data, 0);
        adv();
        stream(8, 100, 1'b1, 1'b0, 1'b0);
        expect_frame("after_rst", 100, 1'b0);

        // N=16 instance
        rst2 = 1'b1;
        adv();
        rst2 = 1'b0;
        for (int unsigned k = 0; k < N2; k++) begin
            in_valid2 = 1'b1;
            in_data2  = W2'(k);
            half();
            check("n16_in_ready", W'(in_ready2), W'(1));
            adv();
        end
        in_valid2 = 1'b0;
        for (int unsigned k = 0; k < N2; k++) begin
            half();
            check("n16_valid", W'(out_valid2), W'(1));
            check("n16_data", W'(out_data2), W'(exp16[k]));
            check("n16_index", W'(out_index2), W'(exp16[k]));
            check("n16_last", W'(out_last2), W'(k == N2 - 1));
            adv();
        end
        half();
        check("n16_idle", W'(out_valid2), W'(0));
        adv();

        // randomized traffic against the model
        for (int unsigned c = 0; c < 1500; c++) begin
            rst          = ($urandom_range(0, 249) == 0);
            in_valid     = ($urandom_range(0, 9) < 7);
            in_data      = $urandom;
            mode_natural = $urandom_range(0, 1) == 1;
            out_ready    = ($urandom_range(0, 9) < 6);
            cyc();
        end
        rst = 1'b0;
        drain(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
